// File: rtl/elixir_pkg.sv
// ============================================================================
// Module  : elixir_pkg
// Brief   : Shared defaults, unit type and cost helper for the elixir bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package elixir_pkg;

  localparam int c_num_ch        = 2;
  localparam int c_max_units     = 10;
  localparam int c_sub_per_unit  = 3;
  localparam int c_ticks_per_sub = 60;
  localparam int c_start_units   = 5;
  localparam int c_bar_x0        = 620;
  localparam int c_bar_pitch     = 20;
  localparam int c_bar_w         = 11;
  localparam int c_bar_y_bot     = 347;
  localparam int c_seg_h         = 11;
  localparam int c_uw            = $clog2(c_max_units + 1);

  typedef logic [c_uw-1:0] elixir_units_t;

  // Whole units to sub-units; 16 bits is wide enough that no legal cost wraps.
  function automatic logic [15:0] ceil_units(input logic [15:0] amt, input int spu);
    return amt * 16'(spu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elixir_bank_if.sv
// ============================================================================
// Module  : elixir_bank_if
// Brief   : Spend handshake, status and HUD draw signals for all pools.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface elixir_bank_if
  import elixir_pkg::*;
#(
  parameter int NUM_CH = c_num_ch,
  parameter int UW     = c_uw
);
  logic [NUM_CH-1:0]         spend_req;
  logic [NUM_CH-1:0][UW-1:0] spend_amt;
  logic [NUM_CH-1:0]         spend_ack;
  logic [NUM_CH-1:0]         spend_nack;
  logic [NUM_CH-1:0][UW-1:0] units_out;
  logic [NUM_CH-1:0]         full;
  logic [9:0]                drawX;
  logic [9:0]                drawY;
  logic [NUM_CH-1:0]         bar_on;

  modport master (
    output spend_req, spend_amt, drawX, drawY,
    input  spend_ack, spend_nack, units_out, full, bar_on
  );

  modport slave (
    input  spend_req, spend_amt, drawX, drawY,
    output spend_ack, spend_nack, units_out, full, bar_on
  );
endinterface

`default_nettype wire

// File: rtl/elixir_channel.sv
// ============================================================================
// Module  : elixir_channel
// Brief   : One elixir pool: regen pacing, spend handshake and HUD bar compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module elixir_channel
  import elixir_pkg::*;
#(
  parameter int MAX_UNITS     = c_max_units,
  parameter int SUB_PER_UNIT  = c_sub_per_unit,
  parameter int TICKS_PER_SUB = c_ticks_per_sub,
  parameter int START_UNITS   = c_start_units,
  parameter int BAR_X0        = c_bar_x0,
  parameter int BAR_W         = c_bar_w,
  parameter int BAR_Y_BOT     = c_bar_y_bot,
  parameter int SEG_H         = c_seg_h,
  parameter int UW            = $clog2(MAX_UNITS + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          active,
  input  wire logic          frame_tick,
  input  wire logic          regen_x2,
  input  wire logic          spend_req,
  input  wire logic [UW-1:0] spend_amt,
  input  wire logic [9:0]    drawX,
  input  wire logic [9:0]    drawY,
  output logic               spend_ack,
  output logic               spend_nack,
  output logic [UW-1:0]      units_out,
  output logic               full,
  output logic               bar_on
);

  localparam int c_cap = MAX_UNITS * SUB_PER_UNIT;
  localparam int c_sw  = $clog2(c_cap + 1);
  localparam int c_tw  = $clog2(TICKS_PER_SUB);

  logic [c_sw-1:0] r_sub;
  logic [c_tw-1:0] r_tick;
  logic            r_ack;
  logic            r_nack;

  logic [c_tw-1:0] w_period_m1;
  logic            w_regen;
  logic [15:0]     w_cost;
  logic            w_accept;
  logic [15:0]     w_sum;
  logic [c_sw-1:0] w_sub_next;
  logic [c_tw-1:0] w_tick_next;
  logic [15:0]     w_x;
  logic [15:0]     w_y;
  logic [15:0]     w_top;

  // ">=" lets a mid-period switch into 2x mode fire on the very next tick.
  assign w_period_m1 = regen_x2 ? c_tw'(TICKS_PER_SUB / 2 - 1) : c_tw'(TICKS_PER_SUB - 1);
  assign w_regen     = frame_tick && (r_tick >= w_period_m1);
  assign w_tick_next = w_regen ? '0 : (frame_tick ? r_tick + c_tw'(1) : r_tick);

  assign w_cost   = ceil_units(16'(spend_amt), SUB_PER_UNIT);
  assign w_accept = spend_req && (w_cost <= 16'(r_sub));

  // An accepted cost never exceeds r_sub, so the difference stays non-negative.
  assign w_sum      = 16'(r_sub) + 16'(w_regen) - (w_accept ? w_cost : 16'd0);
  assign w_sub_next = (w_sum > 16'(c_cap)) ? c_sw'(c_cap) : w_sum[c_sw-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sub  <= c_sw'(START_UNITS * SUB_PER_UNIT);
      r_tick <= '0;
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
    end else if (!active) begin
      r_sub  <= c_sw'(START_UNITS * SUB_PER_UNIT);
      r_tick <= '0;
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
    end else begin
      r_sub  <= w_sub_next;
      r_tick <= w_tick_next;
      r_ack  <= w_accept;
      r_nack <= spend_req && !w_accept;
    end
  end

  assign spend_ack  = r_ack;
  assign spend_nack = r_nack;
  assign units_out  = UW'(r_sub / c_sw'(SUB_PER_UNIT));
  assign full       = (r_sub == c_sw'(c_cap));

  // Bar grows upward from BAR_Y_BOT, SEG_H rows per sub-unit.
  assign w_x   = 16'(drawX);
  assign w_y   = 16'(drawY);
  assign w_top = 16'(BAR_Y_BOT) - 16'(SEG_H) * 16'(r_sub);

  assign bar_on = active && (r_sub != '0)
               && (w_x >= 16'(BAR_X0)) && (w_x <= 16'(BAR_X0 + BAR_W - 1))
               && (w_y <= 16'(BAR_Y_BOT)) && (w_y > w_top);

endmodule

`default_nettype wire

// File: rtl/elixir_bank.sv
// ============================================================================
// Module  : elixir_bank
// Brief   : Multi-player elixir bank; fans shared inputs out to each pool.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module elixir_bank
  import elixir_pkg::*;
#(
  parameter int NUM_CH        = c_num_ch,
  parameter int MAX_UNITS     = c_max_units,
  parameter int SUB_PER_UNIT  = c_sub_per_unit,
  parameter int TICKS_PER_SUB = c_ticks_per_sub,
  parameter int START_UNITS   = c_start_units,
  parameter int BAR_X0        = c_bar_x0,
  parameter int BAR_PITCH     = c_bar_pitch,
  parameter int BAR_W         = c_bar_w,
  parameter int BAR_Y_BOT     = c_bar_y_bot,
  parameter int SEG_H         = c_seg_h
) (
  input  wire logic    clk,
  input  wire logic    reset,
  input  wire logic    active,
  input  wire logic    frame_tick,
  input  wire logic    regen_x2,
  elixir_bank_if.slave bus
);

  localparam int c_uw_local = $clog2(MAX_UNITS + 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    elixir_channel #(
      .MAX_UNITS    (MAX_UNITS),
      .SUB_PER_UNIT (SUB_PER_UNIT),
      .TICKS_PER_SUB(TICKS_PER_SUB),
      .START_UNITS  (START_UNITS),
      .BAR_X0       (BAR_X0 + c * BAR_PITCH),
      .BAR_W        (BAR_W),
      .BAR_Y_BOT    (BAR_Y_BOT),
      .SEG_H        (SEG_H),
      .UW           (c_uw_local)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .active     (active),
      .frame_tick (frame_tick),
      .regen_x2   (regen_x2),
      .spend_req  (bus.spend_req[c]),
      .spend_amt  (bus.spend_amt[c]),
      .drawX      (bus.drawX),
      .drawY      (bus.drawY),
      .spend_ack  (bus.spend_ack[c]),
      .spend_nack (bus.spend_nack[c]),
      .units_out  (bus.units_out[c]),
      .full       (bus.full[c]),
      .bar_on     (bus.bar_on[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_elixir_bank.sv
// ============================================================================
// Module  : tb_elixir_bank
// Brief   : Directed self-checking bench for elixir_bank with default params.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elixir_bank;
  import elixir_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic active;
  logic frame_tick;
  logic regen_x2;
  int   checks = 0;
  int   errors = 0;

  elixir_bank_if #(.NUM_CH(2), .UW(4)) bus ();

  elixir_bank dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .frame_tick(frame_tick),
    .regen_x2  (regen_x2),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  wire [4:0] sub0  = dut.g_ch[0].u_channel.r_sub;
  wire [4:0] sub1  = dut.g_ch[1].u_channel.r_sub;
  wire [5:0] tick0 = dut.g_ch[0].u_channel.r_tick;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic reload();
    active = 1'b0;
    step();
    active = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; active = 1'b0; frame_tick = 1'b0; regen_x2 = 1'b0;
    bus.spend_req = '0; bus.spend_amt = '0; bus.drawX = '0; bus.drawY = '0;
    step(); step();
    checks++; if (bus.units_out !== {4'd5, 4'd5}) begin errors++; $display("FAIL reset_units got %h exp 55", bus.units_out); end
    checks++; if (bus.full !== 2'b00 || bus.bar_on !== 2'b00) begin errors++; $display("FAIL reset_full_bar full %b bar %b exp 00 00", bus.full, bus.bar_on); end
    checks++; if (bus.spend_ack !== 2'b00 || bus.spend_nack !== 2'b00) begin errors++; $display("FAIL reset_hs ack %b nack %b exp 00", bus.spend_ack, bus.spend_nack); end
    reset = 1'b1; active = 1'b1;
    step();
    checks++; if (sub0 !== 5'd15 || sub1 !== 5'd15) begin errors++; $display("FAIL reset_sub got %0d %0d exp 15 15", sub0, sub1); end
  endtask

  task automatic test_regen();
    ticks(59);
    checks++; if (sub0 !== 5'd15) begin errors++; $display("FAIL regen_59 got %0d exp 15", sub0); end
    ticks(1);
    checks++; if (sub0 !== 5'd16 || bus.units_out[0] !== 4'd5) begin errors++; $display("FAIL regen_60 sub %0d units %0d exp 16 5", sub0, bus.units_out[0]); end
    ticks(120);
    checks++; if (sub1 !== 5'd18 || bus.units_out[1] !== 4'd6) begin errors++; $display("FAIL regen_180 sub %0d units %0d exp 18 6", sub1, bus.units_out[1]); end
    regen_x2 = 1'b1;
    ticks(29);
    checks++; if (sub0 !== 5'd18) begin errors++; $display("FAIL regen_x2_29 got %0d exp 18", sub0); end
    ticks(1);
    checks++; if (sub0 !== 5'd19) begin errors++; $display("FAIL regen_x2_30 got %0d exp 19", sub0); end
    // 40 ticks into a 1x period, then switch to 2x: fires on the next tick.
    regen_x2 = 1'b0;
    ticks(40);
    checks++; if (sub0 !== 5'd19 || tick0 !== 6'd40) begin errors++; $display("FAIL regen_mid sub %0d tick %0d exp 19 40", sub0, tick0); end
    regen_x2 = 1'b1;
    ticks(1);
    checks++; if (sub0 !== 5'd20 || tick0 !== 6'd0) begin errors++; $display("FAIL regen_switch sub %0d tick %0d exp 20 0", sub0, tick0); end
    regen_x2 = 1'b0;
  endtask

  task automatic test_spend();
    reload();
    checks++; if (sub0 !== 5'd15 || sub1 !== 5'd15) begin errors++; $display("FAIL spend_reload got %0d %0d exp 15 15", sub0, sub1); end
    bus.spend_req = 2'b11; bus.spend_amt[0] = 4'd3; bus.spend_amt[1] = 4'd7;
    step();
    bus.spend_req = 2'b00;
    checks++; if (bus.spend_ack !== 2'b01 || bus.spend_nack !== 2'b10) begin errors++; $display("FAIL spend_hs ack %b nack %b exp 01 10", bus.spend_ack, bus.spend_nack); end
    checks++; if (sub0 !== 5'd6 || bus.units_out[0] !== 4'd2) begin errors++; $display("FAIL spend_ch0 sub %0d units %0d exp 6 2", sub0, bus.units_out[0]); end
    checks++; if (sub1 !== 5'd15 || bus.units_out[1] !== 4'd5) begin errors++; $display("FAIL spend_ch1 sub %0d units %0d exp 15 5", sub1, bus.units_out[1]); end
    step();
    checks++; if (bus.spend_ack !== 2'b00 || bus.spend_nack !== 2'b00) begin errors++; $display("FAIL spend_pulse ack %b nack %b exp 00 00", bus.spend_ack, bus.spend_nack); end
    bus.spend_req = 2'b01; bus.spend_amt[0] = 4'd0;
    step();
    checks++; if (bus.spend_ack !== 2'b01 || sub0 !== 5'd6) begin errors++; $display("FAIL spend_zero ack %b sub %0d exp 01 6", bus.spend_ack, sub0); end
    bus.spend_amt[0] = 4'd2;
    step();
    checks++; if (bus.spend_ack !== 2'b01 || sub0 !== 5'd0 || bus.units_out[0] !== 4'd0) begin errors++; $display("FAIL spend_exact ack %b sub %0d exp 01 0", bus.spend_ack, sub0); end
    bus.spend_amt[0] = 4'd1;
    step();
    bus.spend_req = 2'b00;
    checks++; if (bus.spend_nack !== 2'b01 || bus.spend_ack !== 2'b00 || sub0 !== 5'd0) begin errors++; $display("FAIL spend_empty nack %b ack %b sub %0d exp 01 00 0", bus.spend_nack, bus.spend_ack, sub0); end
  endtask

  task automatic test_full();
    reload();
    regen_x2 = 1'b1;
    ticks(420);
    checks++; if (sub0 !== 5'd29 || bus.full !== 2'b00) begin errors++; $display("FAIL full_29 sub %0d full %b exp 29 00", sub0, bus.full); end
    ticks(29);
    frame_tick = 1'b1; bus.spend_req = 2'b01; bus.spend_amt[0] = 4'd1;
    step();
    frame_tick = 1'b0; bus.spend_req = 2'b00;
    checks++; if (sub0 !== 5'd27 || bus.spend_ack !== 2'b01) begin errors++; $display("FAIL full_spend_regen sub %0d ack %b exp 27 01", sub0, bus.spend_ack); end
    checks++; if (sub1 !== 5'd30 || bus.full !== 2'b10 || bus.units_out[1] !== 4'd10) begin errors++; $display("FAIL full_cap sub %0d full %b exp 30 10", sub1, bus.full); end
    ticks(120);
    checks++; if (sub1 !== 5'd30 || sub0 !== 5'd30 || bus.full !== 2'b11) begin errors++; $display("FAIL full_hold sub %0d %0d full %b exp 30 30 11", sub0, sub1, bus.full); end
    regen_x2 = 1'b0;
  endtask

  task automatic test_bar();
    reload();
    bus.drawX = 10'd625; bus.drawY = 10'd183; #1;
    checks++; if (bus.bar_on !== 2'b01) begin errors++; $display("FAIL bar_y183 got %b exp 01", bus.bar_on); end
    bus.drawY = 10'd347; #1;
    checks++; if (bus.bar_on !== 2'b01) begin errors++; $display("FAIL bar_y347 got %b exp 01", bus.bar_on); end
    bus.drawY = 10'd182; #1;
    checks++; if (bus.bar_on !== 2'b00) begin errors++; $display("FAIL bar_y182 got %b exp 00", bus.bar_on); end
    bus.drawY = 10'd348; #1;
    checks++; if (bus.bar_on !== 2'b00) begin errors++; $display("FAIL bar_y348 got %b exp 00", bus.bar_on); end
    bus.drawX = 10'd631; bus.drawY = 10'd300; #1;
    checks++; if (bus.bar_on !== 2'b00) begin errors++; $display("FAIL bar_x631 got %b exp 00", bus.bar_on); end
    bus.drawX = 10'd620; #1;
    checks++; if (bus.bar_on !== 2'b01) begin errors++; $display("FAIL bar_x620 got %b exp 01", bus.bar_on); end
    bus.drawX = 10'd645; bus.drawY = 10'd183; #1;
    checks++; if (bus.bar_on !== 2'b10) begin errors++; $display("FAIL bar_ch1 got %b exp 10", bus.bar_on); end
    bus.spend_req = 2'b10; bus.spend_amt[1] = 4'd5;
    step();
    bus.spend_req = 2'b00; bus.drawY = 10'd347; #1;
    checks++; if (bus.bar_on !== 2'b00 || sub1 !== 5'd0) begin errors++; $display("FAIL bar_empty got %b sub %0d exp 00 0", bus.bar_on, sub1); end
    bus.drawX = 10'd625; #1;
    checks++; if (bus.bar_on !== 2'b01) begin errors++; $display("FAIL bar_pre_off got %b exp 01", bus.bar_on); end
    active = 1'b0; #1;
    checks++; if (bus.bar_on !== 2'b00) begin errors++; $display("FAIL bar_inactive got %b exp 00", bus.bar_on); end
    step();
    active = 1'b1;
  endtask

  task automatic test_back_to_back();
    ticks(10);
    bus.spend_req = 2'b01; bus.spend_amt[0] = 4'd2;
    step();
    bus.spend_req = 2'b01; bus.spend_amt[0] = 4'd1;
    step();
    bus.spend_req = 2'b00;
    checks++; if (sub0 !== 5'd6 || bus.spend_ack !== 2'b01 || tick0 !== 6'd10) begin errors++; $display("FAIL b2b sub %0d ack %b tick %0d exp 6 01 10", sub0, bus.spend_ack, tick0); end
    // Sync reload wins over a simultaneous request and tick.
    active = 1'b0; frame_tick = 1'b1; bus.spend_req = 2'b11; bus.spend_amt[0] = 4'd1; bus.spend_amt[1] = 4'd9;
    step();
    active = 1'b1; frame_tick = 1'b0; bus.spend_req = 2'b00;
    checks++; if (sub0 !== 5'd15 || tick0 !== 6'd0 || bus.spend_ack !== 2'b00 || bus.spend_nack !== 2'b00) begin errors++; $display("FAIL sync_reload sub %0d tick %0d ack %b nack %b exp 15 0 00 00", sub0, tick0, bus.spend_ack, bus.spend_nack); end
    ticks(7);
    bus.spend_req = 2'b01; bus.spend_amt[0] = 4'd4;
    step();
    bus.spend_req = 2'b00;
    checks++; if (bus.spend_ack !== 2'b01 || sub0 !== 5'd3) begin errors++; $display("FAIL pre_reset ack %b sub %0d exp 01 3", bus.spend_ack, sub0); end
    reset = 1'b0; #1;
    checks++; if (bus.spend_ack !== 2'b00 || sub0 !== 5'd15 || tick0 !== 6'd0) begin errors++; $display("FAIL async_reset ack %b sub %0d tick %0d exp 00 15 0", bus.spend_ack, sub0, tick0); end
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.units_out !== {4'd5, 4'd5} || bus.spend_ack !== 2'b00) begin errors++; $display("FAIL post_reset units %h ack %b exp 55 00", bus.units_out, bus.spend_ack); end
  endtask

  initial begin
    test_reset();
    test_regen();
    test_spend();
    test_full();
    test_bar();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
